uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver; counterpart of the UART transmitter on the board serial link.
//   Synchronises the asynchronous rx line and samples each bit at mid-bit.
//   Presents a received byte on data with a valid/ack handshake.
//   Flags framing errors and overruns.
// PARAMETERS
//   CLK_FREQ      100_000_000          system clock frequency, Hz
//   BAUD          9600                 line rate, bit/s
//   CLKS_PER_BIT  CLK_FREQ/BAUD(10416) clocks per bit period; derived, do not override
// PORTS
//   clk        in   1  system clock, 100 MHz
//   rst        in   1  asynchronous, active-high reset
//   rx         in   1  serial line; idle high; asynchronous to clk
//   data       out  8  last good byte, LSB received first
//   valid      out  1  data holds an unconsumed byte; stays high until ack
//   ack        in   1  consumer takes data; sampled on the same cycle as valid=1
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   overrun    out  1  sticky: a new byte replaced an unacked byte; cleared by ack
//   busy       out  1  high in START, DATA and STOP
// BEHAVIOUR
//   Reset: all outputs and the shift register clear to 0, state=IDLE. Both synchroniser flops reset to 1.
//   rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s only.
//   Counters: bit timer spans 0..CLKS_PER_BIT-1 (14 bits); bit index spans 0..7 (3 bits).
//   FSM:
//     IDLE : rx_s==0 -> START, timer=0.
//     START: at timer==CLKS_PER_BIT/2-1, re-sample rx_s.
//            rx_s==0 -> DATA, timer=0, idx=0. rx_s==1 -> glitch, back to IDLE with no outputs.
//     DATA : at timer==CLKS_PER_BIT-1, shift rx_s into bit idx and clear timer.
//            At idx==7 go to STOP; otherwise idx+1.
//     STOP : at timer==CLKS_PER_BIT-1 (mid stop bit), sample rx_s.
//            1 -> data<=shift, valid<=1; if valid was 1 and ack==0 that cycle, overrun<=1. Go to IDLE.
//            0 -> frame_err=1 for one cycle; data and valid unchanged. Go to WAIT.
//     WAIT : hold until rx_s==1, then go to IDLE. This stops a held-low/break line from retriggering.
//   Handshake:
//     - ack with valid=1 clears valid and overrun on the next edge.
//     - ack with valid=0 is ignored.
//     - ack on the same cycle as a new byte is committed: the new byte wins. valid stays 1, overrun is not set.
//   Latency: valid rises about 2 + 9.5*CLKS_PER_BIT clocks after the rx falling edge of the start bit.
//     IDLE is re-entered at mid stop bit, so a back-to-back start bit is caught.
//   Reset mid-frame: the partial byte is discarded and the block resumes from IDLE; no valid or frame_err is produced.
//   Tolerance: the transmitter's 104.17 us bit period (10417 clocks) must be received error-free over a full frame.
// TESTING
//   1 Drive 8N1 'A' (0x41) at a 104170 ns bit period -> data=0x41, valid=1, frame_err=0, overrun=0.
//   2 Drive a 2 us low glitch on idle rx -> busy drops within half a bit; no valid, no frame_err.
//   3 Drive 0x55 with stop bit forced low -> one frame_err pulse, valid stays 0.
//       Hold rx low another 3 bit times -> no new frame; a following 0x5A is received correctly.
//   4 Send "Hello" back-to-back with no idle gap, ack each byte on valid -> 48h,65h,6Ch,6Ch,6Fh in order; no errors.
//   5 Send 0x31 then 0x32 with no ack -> data=0x32, overrun=1.
//       Pulse ack -> valid=0, overrun=0. Also ack on the exact commit cycle -> valid=1, overrun=0.
//   6 Assert rst during data bit 4 of a frame -> all outputs 0 immediately.
//       Release rst and send 0x7E -> data=0x7E, valid=1.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised rx, mid-bit sampling, byte held on data with a valid/ack handshake.
// Flags framing errors as a one-cycle pulse and overruns as a sticky bit that ack clears.
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [13:0] BIT_LAST     = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] HALF_LAST    = 14'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT
    } state_t;

    state_t      state, state_n;
    logic        rx_m, rx_s;
    logic [13:0] timer, timer_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  data_n;
    logic        valid_n, overrun_n, frame_err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            timer     <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            state     <= state_n;
            timer     <= timer_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            overrun   <= overrun_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer + 14'd1;
        idx_n       = idx;
        shift_n     = shift;
        data_n      = data;
        valid_n     = valid;
        overrun_n   = overrun;
        frame_err_n = 1'b0;

        if (ack && valid) begin
            valid_n   = 1'b0;
            overrun_n = 1'b0;
        end

        case (state)
            IDLE: begin
                timer_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timer_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_n      = '0;
                    shift_n[idx] = rx_s;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be caught.
                if (timer == BIT_LAST) begin
                    timer_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        if (valid && !ack) overrun_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = WAIT;
                    end
                end
            end
            WAIT: begin
                timer_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    assign busy = (state == START) || (state == DATA) || (state == STOP);

endmodule
